// File: rtl/io_uart_tx_port.sv
// IO-port mapped UART transmitter: CPU stores bytes into a small FIFO, shifted out as 8N1 frames on tx.
// Optional macro UART_TX_PARITY_EN inserts an even-parity bit between the data bits and the stop bit.
module io_uart_tx_port #(
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 4,
    parameter logic [15:0] BASE_ADDR    = 16'h8000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] io_access_addr,
    input  logic [15:0] io_in,
    input  logic        io_write_en,
    input  logic        io_read_en,
    output logic [15:0] io_out,
    output logic        tx
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = $clog2(CLKS_PER_BIT);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    state_t          state_q, state_d;
    logic [BW-1:0]   bitCnt_q, bitCnt_d;
    logic [2:0]      bitIdx_q, bitIdx_d;
    logic [7:0]      shift_q, shift_d;
    logic            parity_q, parity_d;
    logic [7:0]      fifoMem_q [FIFO_DEPTH];
    logic [PW-1:0]   wrPtr_q, rdPtr_q;
    logic [CW-1:0]   count_q, count_d;
    logic            overflow_q, overflow_d;

    logic            selData, selStat, full, empty, busy;
    logic            pushReq, push, pop, bitEnd;
    logic [7:0]      headByte;
    logic            unusedHighByte;

    assign selData        = (io_access_addr == BASE_ADDR);
    assign selStat        = (io_access_addr == BASE_ADDR + 16'd1);
    assign full           = (count_q == CW'(FIFO_DEPTH));
    assign empty          = (count_q == '0);
    assign busy           = (state_q != IDLE) || !empty;
    assign pushReq        = io_write_en && selData;
    assign push           = pushReq && !full;
    assign bitEnd         = (bitCnt_q == BW'(CLKS_PER_BIT - 1));
    assign headByte       = fifoMem_q[rdPtr_q];
    assign unusedHighByte = ^io_in[15:8];

    always_comb begin
        io_out = 16'h0000;
        if (io_read_en && selStat) begin
            io_out = {13'b0, overflow_q, busy, full};
        end else if (io_read_en && selData) begin
            io_out = {15'b0, empty};
        end
    end

    // A store that finds the FIFO full is lost even if the FSM pops in the same cycle.
    always_comb begin
        overflow_d = overflow_q;
        if (io_write_en && selStat) begin
            overflow_d = 1'b0;
        end else if (pushReq && full) begin
            overflow_d = 1'b1;
        end
        count_d = count_q + CW'(push) - CW'(pop);
    end

    always_comb begin
        state_d  = state_q;
        bitCnt_d = bitCnt_q;
        bitIdx_d = bitIdx_q;
        shift_d  = shift_q;
        parity_d = parity_q;
        pop      = 1'b0;
        if (state_q != IDLE) begin
            bitCnt_d = bitEnd ? '0 : bitCnt_q + 1'b1;
        end
        case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop      = 1'b1;
                    shift_d  = headByte;
                    parity_d = ^headByte;
                    bitCnt_d = '0;
                    state_d  = START;
                end
            end
            START: begin
                if (bitEnd) begin
                    bitIdx_d = 3'd0;
                    state_d  = DATA;
                end
            end
            DATA: begin
                if (bitEnd) begin
                    shift_d  = shift_q >> 1;
                    bitIdx_d = bitIdx_q + 1'b1;
                    if (bitIdx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (bitEnd) begin
                    state_d = STOP;
                end
            end
`endif
            STOP: begin
                // Chain straight into the next frame when more bytes are queued.
                if (bitEnd) begin
                    if (!empty) begin
                        pop      = 1'b1;
                        shift_d  = headByte;
                        parity_d = ^headByte;
                        state_d  = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        tx = 1'b1;
        case (state_q)
            START:   tx = 1'b0;
            DATA:    tx = shift_q[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx = parity_q;
`endif
            default: tx = 1'b1;
        endcase
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifoMem_q[wrPtr_q] <= io_in[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            bitCnt_q   <= '0;
            bitIdx_q   <= '0;
            shift_q    <= '0;
            parity_q   <= 1'b0;
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            bitCnt_q   <= bitCnt_d;
            bitIdx_q   <= bitIdx_d;
            shift_q    <= shift_d;
            parity_q   <= parity_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            if (push) begin
                wrPtr_q <= wrPtr_q + 1'b1;
            end
            if (pop) begin
                rdPtr_q <= rdPtr_q + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_io_uart_tx_port.sv
// Directed testbench for io_uart_tx_port with CLKS_PER_BIT=4, FIFO_DEPTH=4.
// Honors UART_TX_PARITY_EN so frame expectations follow the build configuration.
module tb_io_uart_tx_port;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int SLOTS = 11;
`else
    localparam int SLOTS = 10;
`endif
    localparam int FRAME = SLOTS * CPB;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] addr;
    logic [15:0] din;
    logic        we;
    logic        re;
    logic [15:0] dout;
    logic        tx;

    int checks   = 0;
    int failures = 0;

    io_uart_tx_port #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (4),
        .BASE_ADDR    (16'h8000)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .io_access_addr (addr),
        .io_in          (din),
        .io_write_en    (we),
        .io_read_en     (re),
        .io_out         (dout),
        .tx             (tx)
    );

    always #5 clk = ~clk;

    // Expected line level for a given bit slot of a frame carrying byte b.
    function automatic logic expTx(input logic [7:0] b, input int slot);
        if (slot == 0) return 1'b0;
        if (slot <= 8) return b[slot-1];
        if (SLOTS == 11 && slot == 9) return ^b;
        return 1'b1;
    endfunction

    task automatic test_reset();
        rst = 1'b1; we = 1'b0; re = 1'b0; addr = 16'h0000; din = 16'h0000;
        repeat (3) @(negedge clk);
        checks++;
        if (tx !== 1'b1) begin failures++; $display("[TB] FAIL reset_tx got=%b exp=1", tx); end
        re = 1'b1; addr = 16'h8001; #1;
        checks++;
        if (dout !== 16'h0000) begin failures++; $display("[TB] FAIL reset_status got=%h exp=0000", dout); end
        addr = 16'h8000; #1;
        checks++;
        if (dout !== 16'h0001) begin failures++; $display("[TB] FAIL reset_empty got=%h exp=0001", dout); end
        @(negedge clk);
        rst = 1'b0; re = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_frame();
        logic [7:0] b;
        b = 8'hA5;
        @(negedge clk); addr = 16'h8000; din = {8'h00, b}; we = 1'b1;
        @(negedge clk); we = 1'b0; re = 1'b1; addr = 16'h8001;
        for (int k = 0; k < FRAME; k++) begin
            @(negedge clk);
            checks++;
            if (tx !== expTx(b, k / CPB)) begin
                failures++; $display("[TB] FAIL a5_tx k=%0d got=%b exp=%b", k, tx, expTx(b, k / CPB));
            end
            checks++;
            if (dout[1] !== 1'b1) begin failures++; $display("[TB] FAIL a5_busy k=%0d got=%b exp=1", k, dout[1]); end
        end
        @(negedge clk);
        checks++;
        if (dout !== 16'h0000 || tx !== 1'b1) begin
            failures++; $display("[TB] FAIL a5_after status=%h tx=%b exp status=0000 tx=1", dout, tx);
        end
        re = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [7:0] bytes [2];
        bytes[0] = 8'h01; bytes[1] = 8'h80;
        @(negedge clk); addr = 16'h8000; din = 16'h0001; we = 1'b1;
        @(negedge clk); din = 16'h0080;
        for (int k = 0; k < 2 * FRAME; k++) begin
            @(negedge clk);
            if (k == 0) begin we = 1'b0; re = 1'b1; addr = 16'h8001; #1; end
            checks++;
            if (tx !== expTx(bytes[k / FRAME], (k % FRAME) / CPB)) begin
                failures++; $display("[TB] FAIL b2b_tx k=%0d got=%b exp=%b", k, tx, expTx(bytes[k / FRAME], (k % FRAME) / CPB));
            end
            checks++;
            if (dout[1] !== 1'b1) begin failures++; $display("[TB] FAIL b2b_busy k=%0d got=%b exp=1", k, dout[1]); end
        end
        @(negedge clk);
        checks++;
        if (dout !== 16'h0000 || tx !== 1'b1) begin
            failures++; $display("[TB] FAIL b2b_after status=%h tx=%b exp status=0000 tx=1", dout, tx);
        end
        re = 1'b0;
    endtask

    task automatic test_overflow();
        logic [7:0] bytes [6];
        bytes[0] = 8'h11; bytes[1] = 8'h22; bytes[2] = 8'h33;
        bytes[3] = 8'h44; bytes[4] = 8'h55; bytes[5] = 8'h66;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk); addr = 16'h8000; din = {8'h00, bytes[i]}; we = 1'b1;
        end
        for (int k = 4; k < 5 * FRAME; k++) begin
            @(negedge clk);
            if (k == 4) begin
                we = 1'b0; re = 1'b1; addr = 16'h8001; #1;
                checks++;
                if (dout !== 16'h0007) begin failures++; $display("[TB] FAIL ovf_status got=%h exp=0007", dout); end
            end
            if (k == 5) begin we = 1'b1; din = 16'hFFFF; end
            if (k == 6) begin
                we = 1'b0; #1;
                checks++;
                if (dout !== 16'h0003) begin failures++; $display("[TB] FAIL ovf_clear got=%h exp=0003", dout); end
            end
            checks++;
            if (tx !== expTx(bytes[k / FRAME], (k % FRAME) / CPB)) begin
                failures++; $display("[TB] FAIL ovf_tx k=%0d got=%b exp=%b", k, tx, expTx(bytes[k / FRAME], (k % FRAME) / CPB));
            end
        end
        @(negedge clk);
        checks++;
        if (dout !== 16'h0000 || tx !== 1'b1) begin
            failures++; $display("[TB] FAIL ovf_drained status=%h tx=%b exp status=0000 tx=1", dout, tx);
        end
        re = 1'b0;
    endtask

    task automatic test_reset_midframe();
        @(negedge clk); addr = 16'h8000; din = 16'h0000; we = 1'b1;
        @(negedge clk); we = 1'b0; re = 1'b1; addr = 16'h8001;
        repeat (10) @(negedge clk);
        checks++;
        if (tx !== 1'b0) begin failures++; $display("[TB] FAIL midframe_tx got=%b exp=0", tx); end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (tx !== 1'b1 || dout !== 16'h0000) begin
            failures++; $display("[TB] FAIL midframe_reset tx=%b status=%h exp tx=1 status=0000", tx, dout);
        end
        rst = 1'b0;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            checks++;
            if (tx !== 1'b1 || dout !== 16'h0000) begin
                failures++; $display("[TB] FAIL midframe_quiet k=%0d tx=%b status=%h exp tx=1 status=0000", k, tx, dout);
            end
        end
        re = 1'b0;
    endtask

    task automatic test_decode();
        @(negedge clk); re = 1'b1; addr = 16'h8000; #1;
        checks++;
        if (dout !== 16'h0001) begin failures++; $display("[TB] FAIL dec_data_read got=%h exp=0001", dout); end
        addr = 16'h8002; #1;
        checks++;
        if (dout !== 16'h0000) begin failures++; $display("[TB] FAIL dec_other_read got=%h exp=0000", dout); end
        re = 1'b0; addr = 16'h8000; #1;
        checks++;
        if (dout !== 16'h0000) begin failures++; $display("[TB] FAIL dec_no_strobe got=%h exp=0000", dout); end
        @(negedge clk); addr = 16'h8002; din = 16'h00A5; we = 1'b1;
        @(negedge clk); we = 1'b0; re = 1'b1; addr = 16'h8001;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            checks++;
            if (tx !== 1'b1 || dout !== 16'h0000) begin
                failures++; $display("[TB] FAIL dec_store_other k=%0d tx=%b status=%h exp tx=1 status=0000", k, tx, dout);
            end
        end
        re = 1'b0;
    endtask

`ifdef UART_TX_PARITY_EN
    task automatic test_parity();
        logic [7:0] b;
        b = 8'h07;
        @(negedge clk); addr = 16'h8000; din = {8'h00, b}; we = 1'b1;
        @(negedge clk); we = 1'b0; re = 1'b1; addr = 16'h8001;
        for (int k = 0; k < 44; k++) begin
            @(negedge clk);
            checks++;
            if (tx !== expTx(b, k / CPB)) begin
                failures++; $display("[TB] FAIL par_tx k=%0d got=%b exp=%b", k, tx, expTx(b, k / CPB));
            end
            if (k >= 36 && k < 40) begin
                checks++;
                if (tx !== 1'b1) begin failures++; $display("[TB] FAIL par_bit k=%0d got=%b exp=1", k, tx); end
            end
        end
        @(negedge clk);
        checks++;
        if (dout !== 16'h0000 || tx !== 1'b1) begin
            failures++; $display("[TB] FAIL par_after status=%h tx=%b exp status=0000 tx=1", dout, tx);
        end
        re = 1'b0;
    endtask
`endif

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_overflow();
        test_reset_midframe();
        test_decode();
`ifdef UART_TX_PARITY_EN
        test_parity();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
